// File: rtl/cpu_run_ctrl_pkg.sv
// Shared definitions for the CPU run/halt/step sequencer: state encodings,
// default widths and the post-reset state selection.
package cpu_run_ctrl_pkg;

    localparam int PC_W_DEF  = 16;
    localparam int CNT_W_DEF = 32;

    localparam logic [1:0] ST_HALT = 2'b00;
    localparam logic [1:0] ST_RUN  = 2'b01;
    localparam logic [1:0] ST_STEP = 2'b10;
    localparam logic [1:0] ST_BRK  = 2'b11;

    function automatic logic [1:0] reset_state(input bit auto_run);
        return auto_run ? ST_RUN : ST_HALT;
    endfunction

endpackage

// File: rtl/cpu_run_ctrl_btn_edge.sv
// Rising-edge detector for a debounced button level. The history register
// resets to 1 so a button held through reset stays silent until re-pressed.
module btn_edge (
    input  logic clk,
    input  logic rst,
    input  logic btn,
    output logic ev
);

    logic prev;

    always_ff @(posedge clk) begin
        if (!rst) begin
            prev <= 1'b1;
        end else begin
            prev <= btn;
        end
    end

    assign ev = btn & ~prev;

endmodule

// File: rtl/cpu_run_ctrl.sv
// Run/halt/single-step/breakpoint sequencer producing the CPU clock-enable
// and an executed-instruction counter.
//
//   state   | meaning
//   --------+-----------------------------------------------------------
//   ST_HALT | CPU frozen, waiting for a run or step press
//   ST_RUN  | free-running; cpu_en drops when pc hits the breakpoint
//   ST_STEP | exactly one enabled cycle, then back to HALT
//   ST_BRK  | stopped on a breakpoint, bp_hit asserted
module cpu_run_ctrl
    import cpu_run_ctrl_pkg::*;
#(
    parameter int PC_W     = PC_W_DEF,
    parameter int CNT_W    = CNT_W_DEF,
    parameter bit AUTO_RUN = 1'b0
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             run_btn,
    input  logic             halt_btn,
    input  logic             step_btn,
    input  logic             bp_en,
    input  logic [PC_W-1:0]  bp_addr,
    input  logic [PC_W-1:0]  pc,
    output logic             cpu_en,
    output logic [1:0]       state,
    output logic             bp_hit,
    output logic [CNT_W-1:0] instr_count
);

    logic             halt_ev;
    logic             step_ev;
    logic             run_ev;
    logic [1:0]       state_q;
    logic [1:0]       state_d;
    logic             bp_skip_q;
    logic             bp_skip_d;
    logic             bp_match;
    logic [CNT_W-1:0] count_q;

    btn_edge u_halt_edge (.clk(clk), .rst(rst), .btn(halt_btn), .ev(halt_ev));
    btn_edge u_step_edge (.clk(clk), .rst(rst), .btn(step_btn), .ev(step_ev));
    btn_edge u_run_edge  (.clk(clk), .rst(rst), .btn(run_btn),  .ev(run_ev));

    // bp_skip lets a resume from the breakpoint address execute that
    // instruction once instead of trapping on it again.
    assign bp_match = bp_en & (pc == bp_addr) & ~bp_skip_q;

    assign cpu_en = (state_q == ST_STEP) | ((state_q == ST_RUN) & ~bp_match);

    always_comb begin
        state_d   = state_q;
        bp_skip_d = bp_skip_q;
        if ((state_q == ST_RUN) && cpu_en) begin
            bp_skip_d = 1'b0;
        end
        if (halt_ev) begin
            state_d = ST_HALT;
        end else begin
            case (state_q)
                ST_HALT, ST_BRK: begin
                    if (step_ev) begin
                        state_d = ST_STEP;
                    end else if (run_ev) begin
                        state_d   = ST_RUN;
                        bp_skip_d = 1'b1;
                    end
                end
                ST_RUN: begin
                    if (step_ev) begin
                        state_d = ST_HALT;
                    end else if (bp_match) begin
                        state_d = ST_BRK;
                    end
                end
                ST_STEP: state_d = ST_HALT;
                default: state_d = ST_HALT;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q   <= reset_state(AUTO_RUN);
            bp_skip_q <= 1'b0;
            count_q   <= '0;
        end else begin
            state_q   <= state_d;
            bp_skip_q <= bp_skip_d;
            if (cpu_en) begin
                count_q <= count_q + CNT_W'(1);
            end
        end
    end

    assign state       = state_q;
    assign bp_hit      = (state_q == ST_BRK);
    assign instr_count = count_q;

endmodule

// File: tb/tb_cpu_run_ctrl.sv
// Directed bench for cpu_run_ctrl: a tiny PC model follows cpu_en on the
// manual-start instance; two auto-run instances cover reset and wrap.
module tb_cpu_run_ctrl;

    logic        clk = 1'b0;
    always #5 clk = ~clk;

    // instance 0: AUTO_RUN=0, 32-bit counter, PC model attached
    logic        rst0 = 1'b0;
    logic        run0 = 1'b0, halt0 = 1'b0, step0 = 1'b0;
    logic        bp_en0 = 1'b0;
    logic [15:0] bp_addr0 = 16'd4;
    logic [15:0] pc0 = 16'd0;
    logic        cpu_en0, bp_hit0;
    logic [1:0]  state0;
    logic [31:0] count0;

    // instances 1 and 2: AUTO_RUN=1, share stimulus; 2 has a 4-bit counter
    logic        rst1 = 1'b0;
    logic        run1 = 1'b1, halt1 = 1'b0, step1 = 1'b1;
    logic [15:0] zero16 = 16'd0;
    logic        cpu_en1, bp_hit1, cpu_en2, bp_hit2;
    logic [1:0]  state1, state2;
    logic [31:0] count1;
    logic [3:0]  count2;

    int n_total = 0;
    int n_pass  = 0;

    cpu_run_ctrl #(.PC_W(16), .CNT_W(32), .AUTO_RUN(1'b0)) u_dut0 (
        .clk(clk), .rst(rst0), .run_btn(run0), .halt_btn(halt0), .step_btn(step0),
        .bp_en(bp_en0), .bp_addr(bp_addr0), .pc(pc0),
        .cpu_en(cpu_en0), .state(state0), .bp_hit(bp_hit0), .instr_count(count0)
    );

    cpu_run_ctrl #(.PC_W(16), .CNT_W(32), .AUTO_RUN(1'b1)) u_dut1 (
        .clk(clk), .rst(rst1), .run_btn(run1), .halt_btn(halt1), .step_btn(step1),
        .bp_en(1'b0), .bp_addr(zero16), .pc(zero16),
        .cpu_en(cpu_en1), .state(state1), .bp_hit(bp_hit1), .instr_count(count1)
    );

    cpu_run_ctrl #(.PC_W(16), .CNT_W(4), .AUTO_RUN(1'b1)) u_dut2 (
        .clk(clk), .rst(rst1), .run_btn(run1), .halt_btn(halt1), .step_btn(step1),
        .bp_en(1'b0), .bp_addr(zero16), .pc(zero16),
        .cpu_en(cpu_en2), .state(state2), .bp_hit(bp_hit2), .instr_count(count2)
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_total++;
        if (got === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // One clock: cpu_en is sampled mid-cycle, the PC model advances on the edge
    // (looping 0..7), and inputs/outputs settle at posedge+2.
    task automatic tick();
        logic en_s;
        logic r_s;
        @(negedge clk);
        en_s = cpu_en0;
        r_s  = rst0;
        @(posedge clk);
        #1;
        if (!r_s) begin
            pc0 = 16'd0;
        end else if (en_s) begin
            pc0 = (pc0 == 16'd7) ? 16'd0 : pc0 + 16'd1;
        end
        #1;
    endtask

    initial begin
        repeat (2) tick();
        chk("rst_state0", {30'd0, state0}, 32'd0);
        chk("rst_count0", count0, 32'd0);
        chk("rst_state1_autorun", {30'd0, state1}, 32'd1);
        chk("rst_count1", count1, 32'd0);

        // idle after reset release
        rst0 = 1'b1;
        repeat (10) tick();
        chk("idle_state", {30'd0, state0}, 32'd0);
        chk("idle_cpu_en", {31'd0, cpu_en0}, 32'd0);
        chk("idle_count", count0, 32'd0);

        // single step, button held for five cycles
        step0 = 1'b1;
        tick();
        chk("step_state", {30'd0, state0}, 32'd2);
        chk("step_cpu_en", {31'd0, cpu_en0}, 32'd1);
        tick();
        chk("step_back_halt", {30'd0, state0}, 32'd0);
        chk("step_count", count0, 32'd1);
        repeat (3) tick();
        step0 = 1'b0;
        tick();
        chk("step_held_count", count0, 32'd1);
        chk("step_held_pc", {16'd0, pc0}, 32'd1);

        // run into breakpoint at 0x0004
        bp_en0 = 1'b1;
        run0   = 1'b1;
        tick();
        chk("run_state", {30'd0, state0}, 32'd1);
        run0 = 1'b0;
        repeat (3) tick();
        chk("bp_pc", {16'd0, pc0}, 32'd4);
        chk("bp_cpu_en_low", {31'd0, cpu_en0}, 32'd0);
        tick();
        chk("bp_state_brk", {30'd0, state0}, 32'd3);
        chk("bp_hit", {31'd0, bp_hit0}, 32'd1);
        chk("bp_count", count0, 32'd4);
        tick();
        chk("brk_hold_count", count0, 32'd4);

        // resume from breakpoint executes the trapped instruction
        run0 = 1'b1;
        tick();
        chk("resume_cpu_en", {31'd0, cpu_en0}, 32'd1);
        chk("resume_bp_hit", {31'd0, bp_hit0}, 32'd0);
        run0 = 1'b0;
        tick();
        chk("resume_pc", {16'd0, pc0}, 32'd5);
        chk("resume_count", count0, 32'd5);
        repeat (8) tick();
        chk("retrap_state", {30'd0, state0}, 32'd3);
        chk("retrap_count", count0, 32'd12);

        // simultaneous halt+step while running: halt wins
        run0 = 1'b1;
        tick();
        run0 = 1'b0;
        tick();
        halt0 = 1'b1;
        step0 = 1'b1;
        tick();
        chk("halt_step_state", {30'd0, state0}, 32'd0);
        chk("halt_step_count", count0, 32'd14);
        halt0 = 1'b0;
        step0 = 1'b0;
        tick();

        // lone step press while running pauses
        run0 = 1'b1;
        tick();
        run0 = 1'b0;
        tick();
        step0 = 1'b1;
        tick();
        chk("run_step_pause", {30'd0, state0}, 32'd0);
        chk("run_step_count", count0, 32'd16);
        step0 = 1'b0;
        tick();
        chk("pause_stays", {30'd0, state0}, 32'd0);

        // STEP ignores a breakpoint on the current pc
        bp_addr0 = 16'd0;
        step0    = 1'b1;
        tick();
        chk("step_at_bp_en", {31'd0, cpu_en0}, 32'd1);
        tick();
        chk("step_at_bp_pc", {16'd0, pc0}, 32'd1);
        chk("step_at_bp_count", count0, 32'd17);

        // run from HALT while sitting on the breakpoint address
        step0    = 1'b0;
        bp_addr0 = 16'd1;
        tick();
        run0 = 1'b1;
        tick();
        chk("halt_resume_en", {31'd0, cpu_en0}, 32'd1);
        run0 = 1'b0;
        tick();
        halt0 = 1'b1;
        tick();
        chk("halt_resume_state", {30'd0, state0}, 32'd0);
        chk("halt_resume_count", count0, 32'd19);
        halt0 = 1'b0;

        // auto-run instances: buttons held through reset must not fire
        rst1 = 1'b1;
        repeat (5) tick();
        chk("autorun_no_spurious", {30'd0, state1}, 32'd1);
        chk("autorun_count5", count1, 32'd5);
        repeat (4655) tick();
        chk("count_0x1234", count1, 32'h1234);
        chk("count4_mod16", {28'd0, count2}, 32'd4);
        rst1 = 1'b0;
        tick();
        chk("midrun_rst_count", count1, 32'd0);
        chk("midrun_rst_state", {30'd0, state1}, 32'd1);
        rst1 = 1'b1;
        repeat (17) tick();
        chk("wrap_count4", {28'd0, count2}, 32'd1);
        chk("count1_17", count1, 32'd17);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
